// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants: round constants K, initial hash values, round count
// and the FSM encoding used by the e/f/g/h working-variable unit.
package sha256_pkg;

    localparam int unsigned SHA256_WORD_W  = 32;
    localparam int unsigned SHA256_ROUNDS  = 64;
    localparam int unsigned SHA256_ROUND_W = $clog2(SHA256_ROUNDS);

    localparam logic [SHA256_WORD_W-1:0] SHA256_H0 = 32'h6a09e667;
    localparam logic [SHA256_WORD_W-1:0] SHA256_H1 = 32'hbb67ae85;
    localparam logic [SHA256_WORD_W-1:0] SHA256_H2 = 32'h3c6ef372;
    localparam logic [SHA256_WORD_W-1:0] SHA256_H3 = 32'ha54ff53a;
    localparam logic [SHA256_WORD_W-1:0] SHA256_H4 = 32'h510e527f;
    localparam logic [SHA256_WORD_W-1:0] SHA256_H5 = 32'h9b05688c;
    localparam logic [SHA256_WORD_W-1:0] SHA256_H6 = 32'h1f83d9ab;
    localparam logic [SHA256_WORD_W-1:0] SHA256_H7 = 32'h5be0cd19;

    localparam logic [SHA256_WORD_W-1:0] SHA256_K [0:SHA256_ROUNDS-1] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } efg_state_t;

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational SHA-256 round-constant lookup: round index to K[t].
module sha256_k_rom
    import sha256_pkg::*;
(
    input  logic [SHA256_ROUND_W-1:0] addr,
    output logic [SHA256_WORD_W-1:0]  k
);

    assign k = SHA256_K[addr];

endmodule

// File: rtl/sha_efg_gen.sv
// SHA-256 e/f/g/h working-variable chain with round counter and done pulse.
// SHA_EFG_KROM_EN: when defined, kt carries K[round] from an internal ROM during RUN.
module sha_efg_gen
    import sha256_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ROUNDS = SHA256_ROUNDS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       run,
    input  logic [DATA_W-1:0]          init_e,
    input  logic [DATA_W-1:0]          init_f,
    input  logic [DATA_W-1:0]          init_g,
    input  logic [DATA_W-1:0]          init_h,
    input  logic [DATA_W-1:0]          in0,
    output logic [DATA_W-1:0]          out0,
    output logic [DATA_W-1:0]          out1,
    output logic [DATA_W-1:0]          out2,
    output logic [DATA_W-1:0]          out3,
    output logic [DATA_W-1:0]          kt,
    output logic [$clog2(ROUNDS)-1:0]  round,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned        RND_W    = $clog2(ROUNDS);
    localparam logic [RND_W-1:0]   LAST_RND = RND_W'(ROUNDS - 1);

    efg_state_t         state_q, state_d;
    logic [DATA_W-1:0]  e_q, f_q, g_q, h_q;
    logic [DATA_W-1:0]  e_d, f_d, g_d, h_d;
    logic [RND_W-1:0]   round_q, round_d;
    logic               busy_q, done_q, done_d;

    // Next-state: load on accepted run, shift the chain once per round.
    always_comb begin
        state_d = state_q;
        e_d     = e_q;
        f_d     = f_q;
        g_d     = g_q;
        h_d     = h_q;
        round_d = round_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (run) begin
                    e_d     = init_e;
                    f_d     = init_f;
                    g_d     = init_g;
                    h_d     = init_h;
                    round_d = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                h_d = g_q;
                g_d = f_q;
                f_d = e_q;
                e_d = in0;
                if (round_q == LAST_RND) begin
                    round_d = '0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    round_d = round_q + RND_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            e_q     <= '0;
            f_q     <= '0;
            g_q     <= '0;
            h_q     <= '0;
            round_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            e_q     <= e_d;
            f_q     <= f_d;
            g_q     <= g_d;
            h_q     <= h_d;
            round_q <= round_d;
            busy_q  <= (state_d == ST_RUN);
            done_q  <= done_d;
        end
    end

    assign out0  = e_q;
    assign out1  = f_q;
    assign out2  = g_q;
    assign out3  = h_q;
    assign round = round_q;
    assign busy  = busy_q;
    assign done  = done_q;

`ifdef SHA_EFG_KROM_EN
    logic [SHA256_WORD_W-1:0] k_rom;

    sha256_k_rom u_k_rom (
        .addr (SHA256_ROUND_W'(round_q)),
        .k    (k_rom)
    );

    // K is only meaningful while a block is in flight.
    assign kt = busy_q ? DATA_W'(k_rom) : '0;
`else
    assign kt = '0;
`endif

endmodule
